// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the systolic matrix-multiply sequencer.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int unsigned DIM_W = 2;

    function automatic int unsigned feed_len(input int unsigned max_dim);
        return 3 * max_dim - 2;
    endfunction

    function automatic int unsigned drain_len(input int unsigned max_dim);
        return max_dim;
    endfunction

    // Bits needed to index 0..len-1, never less than one.
    function automatic int unsigned cnt_w(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    localparam int unsigned DEF_MAX_DIM = 2;
    localparam int unsigned FEED_LEN    = feed_len(DEF_MAX_DIM);
    localparam int unsigned DRAIN_LEN   = drain_len(DEF_MAX_DIM);

endpackage

// File: rtl/matmul_sequencer_seq_counter.sv
// Up-counter with clear, enable and a registered terminal-count flag; stops at LAST.
module seq_counter #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned LAST  = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= '0;
            tc_o    <= 1'b0;
        end else if (clr_i) begin
            count_o <= '0;
            tc_o    <= 1'(LAST == 0);
        end else if (en_i && !tc_o) begin
            count_o <= WIDTH'(count_o + WIDTH'(1));
            tc_o    <= (WIDTH'(count_o + WIDTH'(1)) == WIDTH'(LAST));
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one systolic matmul: latch dims, reload operands, feed, drain, report done.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter  int unsigned BUS_WIDTH  = 16,
    parameter  int unsigned DATA_WIDTH = 8,
    localparam int unsigned MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int unsigned CNT_W      = $clog2(3 * MAX_DIM - 2)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [DIM_W-1:0] n_i,
    input  logic [DIM_W-1:0] k_i,
    input  logic [DIM_W-1:0] m_i,
    output logic             start_bit_o,
    output logic             reload_op_o,
    output logic [CNT_W-1:0] counter_o,
    output logic [DIM_W-1:0] n_o,
    output logic [DIM_W-1:0] k_o,
    output logic [DIM_W-1:0] m_o,
    output logic             pe_en_o,
    output logic             pe_clr_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned F_LEN   = feed_len(MAX_DIM);
    localparam int unsigned D_LEN   = drain_len(MAX_DIM);
    localparam int unsigned DRAIN_W = cnt_w(D_LEN);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   feed_cnt;
    logic               feed_tc;
    logic [DRAIN_W-1:0] drain_cnt_unused;
    logic               drain_tc;

    logic               start_bit_d, reload_op_d, pe_en_d, pe_clr_d, busy_d, done_d;
    logic [CNT_W-1:0]   counter_d;
    logic [DIM_W-1:0]   n_d, k_d, m_d;

    seq_counter #(.WIDTH(CNT_W), .LAST(F_LEN - 1)) u_feed_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (state_q != FEED),
        .en_i    (state_q == FEED),
        .count_o (feed_cnt),
        .tc_o    (feed_tc)
    );

    seq_counter #(.WIDTH(DRAIN_W), .LAST(D_LEN - 1)) u_drain_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (state_q != DRAIN),
        .en_i    (state_q == DRAIN),
        .count_o (drain_cnt_unused),
        .tc_o    (drain_tc)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, then outputs decoded from the next state so they register in step with it.
    always_comb begin
        state_d     = state_q;
        n_d         = n_o;
        k_d         = k_o;
        m_d         = m_o;
        start_bit_d = 1'b0;
        reload_op_d = 1'b0;
        pe_en_d     = 1'b0;
        pe_clr_d    = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        counter_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = LOAD;
                    n_d     = n_i;
                    k_d     = k_i;
                    m_d     = m_i;
                end
            end
            LOAD:    state_d = FEED;
            FEED:    if (feed_tc) state_d = DRAIN;
            DRAIN:   if (drain_tc) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        unique case (state_d)
            LOAD: begin
                busy_d      = 1'b1;
                pe_clr_d    = 1'b1;
                reload_op_d = 1'b1;
            end
            FEED: begin
                busy_d      = 1'b1;
                start_bit_d = 1'b1;
                pe_en_d     = 1'b1;
                counter_d   = (state_q == FEED) ? CNT_W'(feed_cnt + CNT_W'(1)) : '0;
            end
            DRAIN: begin
                busy_d  = 1'b1;
                pe_en_d = 1'b1;
            end
            DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_bit_o <= 1'b0;
            reload_op_o <= 1'b0;
            counter_o   <= '0;
            n_o         <= '0;
            k_o         <= '0;
            m_o         <= '0;
            pe_en_o     <= 1'b0;
            pe_clr_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            start_bit_o <= start_bit_d;
            reload_op_o <= reload_op_d;
            counter_o   <= counter_d;
            n_o         <= n_d;
            k_o         <= k_d;
            m_o         <= m_d;
            pe_en_o     <= pe_en_d;
            pe_clr_o    <= pe_clr_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer at MAX_DIM=2 and MAX_DIM=4.
module tb_matmul_sequencer;

    typedef struct packed {
        logic       busy;
        logic       start_bit;
        logic       reload;
        logic       pe_en;
        logic       pe_clr;
        logic       done;
        logic [3:0] counter;
        logic [1:0] n;
        logic [1:0] k;
        logic [1:0] m;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] n = 2'd0, k = 2'd0, m = 2'd0;

    logic       s2_start_bit, s2_reload, s2_pe_en, s2_pe_clr, s2_busy, s2_done;
    logic [1:0] s2_counter, s2_n, s2_k, s2_m;
    logic       s4_start_bit, s4_reload, s4_pe_en, s4_pe_clr, s4_busy, s4_done;
    logic [3:0] s4_counter;
    logic [1:0] s4_n, s4_k, s4_m;

    vec_t q2[$];
    vec_t q4[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(.BUS_WIDTH(16), .DATA_WIDTH(8)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .n_i(n), .k_i(k), .m_i(m),
        .start_bit_o(s2_start_bit), .reload_op_o(s2_reload), .counter_o(s2_counter),
        .n_o(s2_n), .k_o(s2_k), .m_o(s2_m),
        .pe_en_o(s2_pe_en), .pe_clr_o(s2_pe_clr), .busy_o(s2_busy), .done_o(s2_done)
    );

    matmul_sequencer #(.BUS_WIDTH(32), .DATA_WIDTH(8)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .n_i(n), .k_i(k), .m_i(m),
        .start_bit_o(s4_start_bit), .reload_op_o(s4_reload), .counter_o(s4_counter),
        .n_o(s4_n), .k_o(s4_k), .m_o(s4_m),
        .pe_en_o(s4_pe_en), .pe_clr_o(s4_pe_clr), .busy_o(s4_busy), .done_o(s4_done)
    );

    function automatic vec_t mk(input logic b, input logic sb, input logic rl, input logic en,
                                input logic clr, input logic dn, input int cnt,
                                input logic [1:0] dn_n, input logic [1:0] dn_k,
                                input logic [1:0] dn_m);
        vec_t v;
        v.busy = b; v.start_bit = sb; v.reload = rl; v.pe_en = en;
        v.pe_clr = clr; v.done = dn; v.counter = 4'(cnt);
        v.n = dn_n; v.k = dn_k; v.m = dn_m;
        return v;
    endfunction

    function automatic void push(input bit four, input vec_t v);
        if (four) q4.push_back(v);
        else      q2.push_back(v);
    endfunction

    function automatic void push_idle(input bit four, input logic [1:0] dn_n,
                                      input logic [1:0] dn_k, input logic [1:0] dn_m);
        push(four, mk(0, 0, 0, 0, 0, 0, 0, dn_n, dn_k, dn_m));
    endfunction

    // Expected cycle-by-cycle outputs of one complete operation, LOAD through DONE.
    function automatic void push_run(input bit four, input int md, input logic [1:0] dn_n,
                                     input logic [1:0] dn_k, input logic [1:0] dn_m);
        push(four, mk(1, 0, 1, 0, 1, 0, 0, dn_n, dn_k, dn_m));
        for (int i = 0; i < 3 * md - 2; i++) push(four, mk(1, 1, 0, 1, 0, 0, i, dn_n, dn_k, dn_m));
        for (int i = 0; i < md; i++)         push(four, mk(1, 0, 0, 1, 0, 0, 0, dn_n, dn_k, dn_m));
        push(four, mk(1, 0, 0, 0, 0, 1, 0, dn_n, dn_k, dn_m));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input bit four);
        vec_t o, e;
        vectors++;
        if (four) begin
            o.busy = s4_busy; o.start_bit = s4_start_bit; o.reload = s4_reload;
            o.pe_en = s4_pe_en; o.pe_clr = s4_pe_clr; o.done = s4_done;
            o.counter = s4_counter; o.n = s4_n; o.k = s4_k; o.m = s4_m;
        end else begin
            o.busy = s2_busy; o.start_bit = s2_start_bit; o.reload = s2_reload;
            o.pe_en = s2_pe_en; o.pe_clr = s2_pe_clr; o.done = s2_done;
            o.counter = {2'b00, s2_counter}; o.n = s2_n; o.k = s2_k; o.m = s2_m;
        end
        if ((four ? q4.size() : q2.size()) == 0) begin
            miscompares++;
            $error("FAIL %s: observed %h with no expected vector queued", tag, o);
        end else begin
            e = four ? q4.pop_front() : q2.pop_front();
            assert (o === e) else begin
                miscompares++;
                $error("FAIL %s @%0t: observed %h expected %h", tag, $time, o, e);
            end
        end
    endtask

    initial begin
        // Reset state, then release and stay idle
        #2;
        push_idle(0, 0, 0, 0); check("reset_state", 0);
        push_idle(1, 0, 0, 0); check("reset_state4", 1);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            push_idle(0, 0, 0, 0);
            check("idle", 0);
        end

        // Nominal single run
        n = 2'd1; k = 2'd1; m = 2'd0; start = 1'b1;
        push_run(0, 2, 1, 1, 0);
        push_idle(0, 1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            step();
            if (i == 0) start = 1'b0;
            check("nominal", 0);
        end

        // Dimension stability and start held across the whole run
        n = 2'd1; k = 2'd1; m = 2'd0; start = 1'b1;
        push_run(0, 2, 1, 1, 0);
        push_idle(0, 1, 1, 0);
        push_run(0, 2, 0, 0, 0);
        push_idle(0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 2) begin n = 2'd0; k = 2'd0; end
            if (i == 9) start = 1'b0;
            check("stability", 0);
        end

        // Abort in FEED at counter 2, no done afterwards
        n = 2'd1; k = 2'd0; m = 2'd1; start = 1'b1;
        push(0, mk(1, 0, 1, 0, 1, 0, 0, 1, 0, 1));
        for (int i = 0; i < 3; i++) push(0, mk(1, 1, 0, 1, 0, 0, i, 1, 0, 1));
        for (int i = 0; i < 11; i++) push_idle(0, 1, 0, 1);
        for (int i = 0; i < 15; i++) begin
            step();
            if (i == 0) start = 1'b0;
            if (i == 3) abort = 1'b1;
            if (i == 4) abort = 1'b0;
            check("abort", 0);
        end

        // Async reset between edges in DRAIN
        n = 2'd0; k = 2'd1; m = 2'd1; start = 1'b1;
        push(0, mk(1, 0, 1, 0, 1, 0, 0, 0, 1, 1));
        for (int i = 0; i < 4; i++) push(0, mk(1, 1, 0, 1, 0, 0, i, 0, 1, 1));
        push(0, mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) start = 1'b0;
            check("pre_reset", 0);
        end
        #2 rst_n = 1'b0;
        #1;
        push_idle(0, 0, 0, 0); check("async_reset", 0);
        push_idle(1, 0, 0, 0); check("async_reset4", 1);
        #3 rst_n = 1'b1;

        // Fresh run after reset on both widths: 7 and 15 cycle latency
        n = 2'd2; k = 2'd3; m = 2'd1; start = 1'b1;
        push_run(0, 2, 2, 3, 1);
        for (int i = 0; i < 9; i++) push_idle(0, 2, 3, 1);
        push_run(1, 4, 2, 3, 1);
        push_idle(1, 2, 3, 1);
        for (int i = 0; i < 17; i++) begin
            step();
            if (i == 0) start = 1'b0;
            check("post_reset", 0);
            check("maxdim4", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
